// File: rtl/croc_pkg.sv
// croc_pkg: OBI subordinate types plus user-domain register map for the counter block
// Exposes sbr_obi_req_t/sbr_obi_rsp_t, UserBaseAddr, counter offsets/bit indices, be_merge helper
package croc_pkg;
  localparam int unsigned SbrIdWidth = 4;
  typedef struct packed {
    logic [31:0]           addr;
    logic                  we;
    logic [3:0]            be;
    logic [31:0]           wdata;
    logic [SbrIdWidth-1:0] aid;
    logic                  a_optional;
  } sbr_obi_a_chan_t;
  typedef struct packed {
    sbr_obi_a_chan_t a;
    logic            req;
  } sbr_obi_req_t;
  typedef struct packed {
    logic [31:0]           rdata;
    logic [SbrIdWidth-1:0] rid;
    logic                  err;
    logic                  r_optional;
  } sbr_obi_r_chan_t;
  typedef struct packed {
    sbr_obi_r_chan_t r;
    logic            gnt;
    logic            rvalid;
  } sbr_obi_rsp_t;
  localparam logic [31:0] UserBaseAddr = 32'h2000_0000;
  // user domain: simple counter
  localparam logic [4:0] CntCtrlOff     = 5'h00;
  localparam logic [4:0] CntCountOff    = 5'h04;
  localparam logic [4:0] CntCompareOff  = 5'h08;
  localparam logic [4:0] CntStatusOff   = 5'h0C;
  localparam logic [4:0] CntPrescaleOff = 5'h10;
  localparam int unsigned CtrlEnBit         = 0;
  localparam int unsigned CtrlIrqEnBit      = 1;
  localparam int unsigned CtrlAutoReloadBit = 2;
  localparam int unsigned CtrlClearBit      = 3;
  localparam int unsigned StatMatchBit      = 0;
  localparam int unsigned StatOvfBit        = 1;
  function automatic logic [31:0] be_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    return {be[3] ? new_v[31:24] : old_v[31:24], be[2] ? new_v[23:16] : old_v[23:16],
            be[1] ? new_v[15:8] : old_v[15:8], be[0] ? new_v[7:0] : old_v[7:0]};
  endfunction
endpackage

// File: rtl/simple_cnt_core.sv
// simple_cnt_core: prescaler, 32-bit counter, compare/overflow detection
// Ports: clk_i/rst_i; en_i, auto_reload_i, clear_i controls; cnt_we_i/cnt_wdata_i SW count write;
// compare_i, prescale_i, psc_rst_i; count_o value; match_set_o/ovf_set_o one-cycle STATUS set pulses
module simple_cnt_core (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        en_i,
  input  logic        auto_reload_i,
  input  logic        clear_i,
  input  logic        cnt_we_i,
  input  logic [31:0] cnt_wdata_i,
  input  logic [31:0] compare_i,
  input  logic [7:0]  prescale_i,
  input  logic        psc_rst_i,
  output logic [31:0] count_o,
  output logic        match_set_o,
  output logic        ovf_set_o
);
  logic [7:0]  psc_q, psc_d;
  logic [31:0] count_q, count_d;
  logic        tick;
  always_comb begin
    tick        = en_i && psc_q == prescale_i;
    psc_d       = (psc_rst_i || !en_i || tick) ? '0 : psc_q + 8'd1;
    match_set_o = tick && count_q == compare_i;
    ovf_set_o   = tick && &count_q;
    count_d     = clear_i ? '0 : cnt_we_i ? cnt_wdata_i : !tick ? count_q :
                  (match_set_o && auto_reload_i) ? '0 : count_q + 32'd1;
  end
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      psc_q   <= '0;
      count_q <= '0;
    end else begin
      psc_q   <= psc_d;
      count_q <= count_d;
    end
  end
  assign count_o = count_q;
endmodule

// File: rtl/simple_cnt_obi.sv
// simple_cnt_obi: OBI-attached prescaled counter with compare match, overflow and level IRQ
// Ports: clk_i, rst_i (async, active-high); obi_req_i/obi_rsp_o OBI subordinate; irq_o level interrupt
module simple_cnt_obi
  import croc_pkg::*;
#(
  parameter type obi_req_t = croc_pkg::sbr_obi_req_t,
  parameter type obi_rsp_t = croc_pkg::sbr_obi_rsp_t
) (
  input  logic     clk_i,
  input  logic     rst_i,
  input  obi_req_t obi_req_i,
  output obi_rsp_t obi_rsp_o,
  output logic     irq_o
);
  logic [2:0]            ctrl_q, ctrl_d;
  logic [31:0]           compare_q, compare_d;
  logic [1:0]            status_q, status_d, status_set, w1c;
  logic [7:0]            prescale_q, prescale_d;
  logic                  rvalid_q, err_q;
  logic [SbrIdWidth-1:0] rid_q;
  logic [31:0]           rdata_q, rdata_d, count, addr, wdata;
  logic [3:0]            be;
  logic [2:0]            sel;
  logic                  bad, wr, rd, clear, match_set, ovf_set, unused_bits;
  assign addr        = obi_req_i.a.addr;
  assign wdata       = obi_req_i.a.wdata;
  assign be          = obi_req_i.a.be;
  assign sel         = addr[4:2];
  assign unused_bits = ^{addr[31:5], obi_req_i.a.a_optional};
  always_comb begin
    bad        = addr[1:0] != 2'b00 || sel > CntPrescaleOff[4:2];
    wr         = obi_req_i.req && !bad && obi_req_i.a.we;
    rd         = obi_req_i.req && !bad && !obi_req_i.a.we;
    clear      = wr && sel == CntCtrlOff[4:2] && be[0] && wdata[CtrlClearBit];
    ctrl_d     = (wr && sel == CntCtrlOff[4:2] && be[0]) ? wdata[2:0] : ctrl_q;
    compare_d  = (wr && sel == CntCompareOff[4:2]) ? be_merge(compare_q, wdata, be) : compare_q;
    prescale_d = (wr && sel == CntPrescaleOff[4:2] && be[0]) ? wdata[7:0] : prescale_q;
    w1c        = (wr && sel == CntStatusOff[4:2] && be[0]) ? wdata[1:0] : 2'b00;
    status_set = '0;
    status_set[StatMatchBit] = match_set;
    status_set[StatOvfBit]   = ovf_set;
    // hardware set is OR-ed after the clear so it wins a same-cycle W1C
    status_d   = (status_q & ~w1c) | status_set;
    rdata_d    = !rd ? '0 :
                 sel == CntCtrlOff[4:2]    ? {29'b0, ctrl_q} :
                 sel == CntCountOff[4:2]   ? count :
                 sel == CntCompareOff[4:2] ? compare_q :
                 sel == CntStatusOff[4:2]  ? {30'b0, status_q} : {24'b0, prescale_q};
  end
  simple_cnt_core u_core (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .en_i         (ctrl_q[CtrlEnBit]),
    .auto_reload_i(ctrl_q[CtrlAutoReloadBit]),
    .clear_i      (clear),
    .cnt_we_i     (wr && sel == CntCountOff[4:2]),
    .cnt_wdata_i  (be_merge(count, wdata, be)),
    .compare_i    (compare_q),
    .prescale_i   (prescale_q),
    .psc_rst_i    (wr && sel == CntPrescaleOff[4:2]),
    .count_o      (count),
    .match_set_o  (match_set),
    .ovf_set_o    (ovf_set)
  );
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl_q     <= '0;
      compare_q  <= '0;
      status_q   <= '0;
      prescale_q <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
      rid_q      <= '0;
      rdata_q    <= '0;
    end else begin
      ctrl_q     <= ctrl_d;
      compare_q  <= compare_d;
      status_q   <= status_d;
      prescale_q <= prescale_d;
      rvalid_q   <= obi_req_i.req;
      err_q      <= obi_req_i.req && bad;
      rid_q      <= obi_req_i.req ? obi_req_i.a.aid : rid_q;
      rdata_q    <= rdata_d;
    end
  end
  always_comb begin
    obi_rsp_o              = '0;
    obi_rsp_o.gnt          = obi_req_i.req;
    obi_rsp_o.rvalid       = rvalid_q;
    obi_rsp_o.r.rdata      = rdata_q;
    obi_rsp_o.r.rid        = rid_q;
    obi_rsp_o.r.err        = err_q;
    obi_rsp_o.r.r_optional = 1'b0;
  end
  assign irq_o = ctrl_q[CtrlIrqEnBit] & (status_q[StatMatchBit] | status_q[StatOvfBit]);
endmodule

// File: tb/tb_simple_cnt_obi.sv
// tb_simple_cnt_obi: directed self-checking bench for simple_cnt_obi
module tb_simple_cnt_obi;
  import croc_pkg::*;
  logic         clk = 1'b0;
  logic         rst;
  sbr_obi_req_t req;
  sbr_obi_rsp_t rsp;
  logic         irq;
  int           checks = 0;
  int           errors = 0;
  int           n;
  always #5 clk = ~clk;
  simple_cnt_obi dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .obi_req_i(req),
    .obi_rsp_o(rsp),
    .irq_o    (irq)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic wr(input string tag, input logic [31:0] addr, input logic [31:0] data,
                    input logic [3:0] be, input logic exp_err);
    req.req = 1'b1;
    req.a.addr = addr;
    req.a.we = 1'b1;
    req.a.be = be;
    req.a.wdata = data;
    req.a.aid = 4'h5;
    req.a.a_optional = 1'b0;
    #1 chk({tag, "_gnt"}, {31'b0, rsp.gnt}, 32'd1);
    @(posedge clk);
    #1 req.req = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, rsp.rvalid}, 32'd1);
    chk({tag, "_err"}, {31'b0, rsp.r.err}, {31'b0, exp_err});
    chk({tag, "_rdata"}, rsp.r.rdata, 32'd0);
    chk({tag, "_rid"}, {28'b0, rsp.r.rid}, 32'd5);
  endtask
  task automatic rd(input string tag, input logic [31:0] addr, input logic [3:0] aid,
                    input logic [31:0] exp_data, input logic exp_err);
    req.req = 1'b1;
    req.a.addr = addr;
    req.a.we = 1'b0;
    req.a.be = 4'hF;
    req.a.wdata = 32'hDEAD_BEEF;
    req.a.aid = aid;
    req.a.a_optional = 1'b0;
    #1 chk({tag, "_gnt"}, {31'b0, rsp.gnt}, 32'd1);
    @(posedge clk);
    #1 req.req = 1'b0;
    chk({tag, "_rvalid"}, {31'b0, rsp.rvalid}, 32'd1);
    chk({tag, "_err"}, {31'b0, rsp.r.err}, {31'b0, exp_err});
    chk({tag, "_rid"}, {28'b0, rsp.r.rid}, {28'b0, aid});
    chk({tag, "_ropt"}, {31'b0, rsp.r.r_optional}, 32'd0);
    chk({tag, "_rdata"}, rsp.r.rdata, exp_data);
  endtask
  task automatic rd_all_zero(input string tag);
    rd({tag, "_ctrl"}, 32'h00, 4'h1, 32'd0, 1'b0);
    rd({tag, "_count"}, 32'h04, 4'h2, 32'd0, 1'b0);
    rd({tag, "_compare"}, 32'h08, 4'h3, 32'd0, 1'b0);
    rd({tag, "_status"}, 32'h0C, 4'h4, 32'd0, 1'b0);
    rd({tag, "_prescale"}, 32'h10, 4'h5, 32'd0, 1'b0);
    chk({tag, "_irq"}, {31'b0, irq}, 32'd0);
  endtask
  initial begin
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 chk("rst_rvalid", {31'b0, rsp.rvalid}, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    rst = 1'b0;
    #1 chk("idle_gnt", {31'b0, rsp.gnt}, 32'd0);
    @(posedge clk);
    #1 rd_all_zero("reset");
    // compare match raises irq on the sixth tick
    wr("m_cmp", 32'h08, 32'd5, 4'hF, 1'b0);
    wr("m_psc", 32'h10, 32'd0, 4'hF, 1'b0);
    wr("m_ctrl", 32'h00, 32'h3, 4'hF, 1'b0);
    n = 0;
    while (!irq && n < 50) begin
      @(posedge clk);
      #1 n++;
    end
    chk("m_ticks", n, 32'd6);
    rd("m_count", 32'h04, 4'h1, 32'd6, 1'b0);
    rd("m_status", 32'h0C, 4'h2, 32'h1, 1'b0);
    chk("m_irq", {31'b0, irq}, 32'd1);
    wr("m_off", 32'h00, 32'h0, 4'hF, 1'b0);
    wr("m_w1c", 32'h0C, 32'h3, 4'hF, 1'b0);
    rd("m_status_clr", 32'h0C, 4'h3, 32'h0, 1'b0);
    // overflow from 0xFFFF_FFFE after two ticks
    wr("o_cnt", 32'h04, 32'hFFFF_FFFE, 4'hF, 1'b0);
    wr("o_ctrl", 32'h00, 32'h3, 4'hF, 1'b0);
    @(posedge clk);
    #1 wr("o_stop", 32'h00, 32'h2, 4'hF, 1'b0);
    rd("o_count", 32'h04, 4'h4, 32'd0, 1'b0);
    rd("o_status", 32'h0C, 4'h5, 32'h2, 1'b0);
    chk("o_irq", {31'b0, irq}, 32'd1);
    wr("o_w1c", 32'h0C, 32'h2, 4'hF, 1'b0);
    rd("o_status_clr", 32'h0C, 4'h6, 32'h0, 1'b0);
    chk("o_irq_clr", {31'b0, irq}, 32'd0);
    // byte enables
    wr("b_full", 32'h08, 32'h1122_3344, 4'hF, 1'b0);
    wr("b_part", 32'h08, 32'hAABB_CCDD, 4'b0010, 1'b0);
    rd("b_cmp", 32'h08, 4'h7, 32'h1122_CC44, 1'b0);
    // prescale 3 over 40 enabled cycles
    wr("p_cnt", 32'h04, 32'd0, 4'hF, 1'b0);
    wr("p_psc", 32'h10, 32'd3, 4'hF, 1'b0);
    wr("p_on", 32'h00, 32'h1, 4'hF, 1'b0);
    repeat (39) @(posedge clk);
    #1 wr("p_off", 32'h00, 32'h0, 4'hF, 1'b0);
    rd("p_count", 32'h04, 4'h8, 32'd10, 1'b0);
    rd("p_psc_rd", 32'h10, 4'h9, 32'd3, 1'b0);
    wr("p_psc0", 32'h10, 32'd0, 4'hF, 1'b0);
    // auto reload at COMPARE=2
    wr("a_cmp", 32'h08, 32'd2, 4'hF, 1'b0);
    wr("a_cnt", 32'h04, 32'd0, 4'hF, 1'b0);
    wr("a_on", 32'h00, 32'h5, 4'hF, 1'b0);
    repeat (2) @(posedge clk);
    #1 wr("a_off", 32'h00, 32'h0, 4'hF, 1'b0);
    rd("a_count", 32'h04, 4'hA, 32'd0, 1'b0);
    rd("a_status", 32'h0C, 4'hB, 32'h1, 1'b0);
    wr("a_w1c", 32'h0C, 32'h1, 4'hF, 1'b0);
    // hardware set beats same-cycle W1C
    wr("s_cmp", 32'h08, 32'd3, 4'hF, 1'b0);
    wr("s_cnt", 32'h04, 32'd3, 4'hF, 1'b0);
    wr("s_on", 32'h00, 32'h1, 4'hF, 1'b0);
    wr("s_w1c", 32'h0C, 32'h1, 4'hF, 1'b0);
    wr("s_off", 32'h00, 32'h0, 4'hF, 1'b0);
    rd("s_status", 32'h0C, 4'hC, 32'h1, 1'b0);
    rd("s_count", 32'h04, 4'hD, 32'd5, 1'b0);
    // clear pulse
    wr("c_cnt", 32'h04, 32'h1234, 4'hF, 1'b0);
    wr("c_clr", 32'h00, 32'h8, 4'hF, 1'b0);
    rd("c_ctrl", 32'h00, 4'hE, 32'h0, 1'b0);
    rd("c_count", 32'h04, 4'hF, 32'h0, 1'b0);
    // decode errors leave state untouched
    rd("e_rd18", 32'h18, 4'h3, 32'h0, 1'b1);
    wr("e_mis", 32'h09, 32'hFF, 4'hF, 1'b1);
    wr("e_wr14", 32'h14, 32'hFF, 4'hF, 1'b1);
    rd("e_cmp", 32'h08, 4'h1, 32'd3, 1'b0);
    // reset right after a read grant
    wr("r_ctrl", 32'h00, 32'h2, 4'hF, 1'b0);
    chk("r_irq_pre", {31'b0, irq}, 32'd1);
    req.req = 1'b1;
    req.a.addr = 32'h08;
    req.a.we = 1'b0;
    req.a.be = 4'hF;
    req.a.aid = 4'h2;
    @(posedge clk);
    #1 req.req = 1'b0;
    rst = 1'b1;
    #1 chk("r_rvalid_async", {31'b0, rsp.rvalid}, 32'd0);
    @(posedge clk);
    #1 chk("r_rvalid_hold", {31'b0, rsp.rvalid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("r_rvalid_after", {31'b0, rsp.rvalid}, 32'd0);
    rd_all_zero("post_rst");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/simple_cnt_obi.md
SIMPLE_CNT_OBI -- requirements
Module: simple_cnt_obi

Interface
REQ-001 Parameter obi_req_t, default croc_pkg::sbr_obi_req_t: OBI subordinate request type.
REQ-002 Parameter obi_rsp_t, default croc_pkg::sbr_obi_rsp_t: OBI subordinate response type.
REQ-003 Port clk_i, input, 1: single clock; all state on rising edge.
REQ-004 Port rst_i, input, 1: reset, asynchronous, active-high.
REQ-005 Port obi_req_i, input, obi_req_t: request from the user-domain crossbar port.
REQ-006 Port obi_rsp_o, output, obi_rsp_t: response to the crossbar.
REQ-007 Port irq_o, output, 1: level interrupt into one croc external IRQ line.

Function
REQ-008 Register map, decoded on addr[4:2], word-aligned:
- 0x00 CTRL RW: [0] enable, [1] irq_en, [2] auto_reload, [3] clear (write-1 pulse, reads 0).
- 0x04 COUNT RW, 32 bit.
- 0x08 COMPARE RW, 32 bit.
- 0x0C STATUS: [0] match, [1] overflow; sticky, write-1-to-clear.
- 0x10 PRESCALE RW: [7:0].
REQ-009 gnt SHALL equal req combinationally; every request is accepted in its request cycle.
REQ-010 rvalid SHALL assert exactly one cycle after each accepted request, with rid equal to the registered aid.
REQ-011 Read rdata SHALL be registered and reflect register values at the grant cycle; writes return rdata 0.
REQ-012 Writes SHALL honour be per byte; unwritten bytes keep their value.
REQ-013 Offsets 0x14 and above, and addr[1:0] != 0, SHALL return err=1 one cycle later with rdata 0 and no state change.
REQ-014 Prescaler counter SHALL produce a one-cycle tick every PRESCALE+1 cycles while enable=1; it SHALL hold at 0 while enable=0.
REQ-015 On tick, COUNT SHALL increment by 1, modulo 2^32.
REQ-016 On a tick taking COUNT from 0xFFFF_FFFF to 0, overflow SHALL set.
REQ-017 On a tick where COUNT equals COMPARE before the increment, match SHALL set. If auto_reload=1, the next COUNT SHALL be 0 instead of COUNT+1.
REQ-018 Precedence for COUNT in one cycle: clear > SW write to COUNT > tick update.
REQ-019 On simultaneous W1C and a hardware set of the same STATUS bit, set SHALL win.
REQ-020 Writing PRESCALE SHALL reset the prescaler counter to 0.
REQ-021 irq_o SHALL equal irq_en & (match | overflow), driven from flops with no combinational path from OBI inputs.
REQ-022 The block SHALL use no FSM beyond a 1-state response pipeline: valid, rid, err, rdata flops.

Reset
REQ-023 On rst_i, all of the following SHALL be 0: CTRL, COUNT, COMPARE, STATUS, PRESCALE, prescaler counter, rvalid, err, rid, rdata, and irq_o.
REQ-024 Reset asserted mid-transaction SHALL drop a pending rvalid; no response SHALL be emitted after reset.
REQ-025 The r_optional field SHALL always be driven 0.

Structure
REQ-026 Register offsets and CTRL/STATUS bit indices SHALL be localparams in croc_pkg under a user-domain section.
REQ-027 The base address SHALL come from croc_pkg::UserBaseAddr in the user-domain demux, not from this block.
REQ-028 One sub-module is natural: simple_cnt_core, holding the prescaler, counter, compare logic and STATUS set pulses. simple_cnt_obi holds the OBI decode and response pipeline.

Verification
REQ-029 Write COMPARE=5, PRESCALE=0, CTRL=0x3; poll -> match and irq_o set 6 ticks after enable; COUNT=6 at detection.
REQ-030 Write COUNT=0xFFFF_FFFE, enable -> after 2 ticks COUNT=0, overflow=1; W1C STATUS=0x2 -> overflow=0 and irq_o low.
REQ-031 Write PRESCALE=3, enable for 40 cycles -> COUNT=10 (±1 for the enable edge).
REQ-032 Read offset 0x18 with aid=3 -> gnt in the same cycle; next cycle rvalid=1, err=1, rid=3, rdata=0.
REQ-033 Write COMPARE with be=4'b0010, wdata=0xAABBCCDD over 0x11223344 -> COMPARE=0x1122CC44.
REQ-034 Assert rst_i in the cycle after a read grant -> rvalid stays 0; all registers read 0 afterwards.
